uart_axi_tx: RTL and testbench



---
 rtl/uart_axi_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_axi_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_axi_tx.sv
// uart_axi_tx: AXI-Stream byte sink feeding a UART transmitter through a small
// elastic FIFO. Frame: start bit, DATA_WIDTH data bits LSB-first, optional even
// parity, STOP_BITS stop bits. Each bit lasts P clocks, P latched from
// clk_per_bit when a byte is popped (0 and 1 both mean P=1).
// Optional feature macro: UART_AXI_TX_PARITY_EN adds one even-parity bit
// between the data bits and the stop bit(s).
module uart_axi_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_BITS   = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CLK_BITS-1:0]   clk_per_bit,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic                  uart_tx,
  output logic                  busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_AXI_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  // Transmitter state
  state_t                state;
  state_t                state_nxt;
  logic [CLK_BITS-1:0]   cnt;
  logic [CLK_BITS-1:0]   cnt_nxt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [CLK_BITS-1:0]   period;
  logic [CLK_BITS-1:0]   period_nxt;
  logic [CLK_BITS-1:0]   eff_period;
  logic                  tx;
  logic                  tx_nxt;
  logic                  bit_end;
  logic                  load;
`ifdef UART_AXI_TX_PARITY_EN
  logic                  parity_bit;
  logic                  parity_nxt;
`endif

  // s_tready is forced low while reset is held so nothing is accepted then.
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign s_tready   = ~rst & ~full;
  assign push       = s_tvalid & s_tready;
  assign head       = mem[rd_ptr];
  assign pop        = load;

  assign eff_period = (clk_per_bit <= CLK_BITS'(1)) ? CLK_BITS'(1) : clk_per_bit;
  assign bit_end    = (cnt == period - CLK_BITS'(1));

  assign uart_tx = tx;
  assign busy    = (state != IDLE) | ~fifo_empty;

  // FIFO payload write; storage needs no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep count steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Next-state, bit timing and line value; the line is registered from state_nxt
  // so the start bit appears on the same edge that pops the byte.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    shift_nxt  = shift;
    period_nxt = period;
    load       = 1'b0;
`ifdef UART_AXI_TX_PARITY_EN
    parity_nxt = parity_bit;
`endif
    unique case (state)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CLK_BITS'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          shift_nxt = shift >> 1;
          if (idx == IDX_W'(DATA_WIDTH - 1)) begin
            idx_nxt   = '0;
`ifdef UART_AXI_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CLK_BITS'(1);
        end
      end
`ifdef UART_AXI_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CLK_BITS'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (idx == IDX_W'(STOP_BITS - 1)) begin
            idx_nxt = '0;
            if (!fifo_empty) load = 1'b1;
            else             state_nxt = IDLE;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CLK_BITS'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A pop starts a new frame from either IDLE or the end of the last stop bit.
    if (load) begin
      state_nxt  = START;
      cnt_nxt    = '0;
      idx_nxt    = '0;
      shift_nxt  = head;
      period_nxt = eff_period;
`ifdef UART_AXI_TX_PARITY_EN
      parity_nxt = ^head;
`endif
    end

    tx_nxt = 1'b1;
    unique case (state_nxt)
      IDLE:    tx_nxt = 1'b1;
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_AXI_TX_PARITY_EN
      PARITY:  tx_nxt = parity_nxt;
`endif
      STOP:    tx_nxt = 1'b1;
      default: tx_nxt = 1'b1;
    endcase
  end

  // Control registers: state, counters and the registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      tx    <= tx_nxt;
    end
  end

  // Frame data registers; only meaningful after a pop has loaded them.
  always_ff @(posedge clk) begin
    shift  <= shift_nxt;
    period <= period_nxt;
`ifdef UART_AXI_TX_PARITY_EN
    parity_bit <= parity_nxt;
`endif
  end

endmodule

// File: tb/tb_uart_axi_tx.sv
// tb_uart_axi_tx: drives directed and random byte streams into uart_axi_tx and
// compares uart_tx, busy and s_tready every cycle against a frame-level model
// that expands each popped byte into its expected per-cycle line waveform.
module tb_uart_axi_tx;

  localparam int DW    = 8;
  localparam int CB    = 9;
  localparam int DEPTH = 4;
  localparam int STOPS = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CB-1:0] clk_per_bit = 9'd4;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          uart_tx;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [DW-1:0] byteq[$];
  bit            expq[$];
  bit            model_active = 1'b0;
  bit            last_acc = 1'b0;

  uart_axi_tx #(
    .DATA_WIDTH(DW),
    .CLK_BITS  (CB),
    .FIFO_DEPTH(DEPTH),
    .STOP_BITS (STOPS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_per_bit(clk_per_bit),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .uart_tx    (uart_tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expand one byte into its line waveform: every frame bit repeated p cycles.
  task automatic add_frame(input logic [DW-1:0] b, input int p);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(b[i]);
`ifdef UART_AXI_TX_PARITY_EN
    bits.push_back(^b);
`endif
    for (int i = 0; i < STOPS; i++) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < p; k++) expq.push_back(bits[i]);
  endtask

  // One clock: sample handshake before the edge, advance model, check after.
  task automatic tick();
    bit            acc;
    bit            r;
    logic [DW-1:0] d;
    int            p;
    bit            exp_tx;
    @(negedge clk);
    r   = rst;
    acc = s_tvalid && s_tready && !rst;
    d   = s_tdata;
    p   = (clk_per_bit <= 1) ? 1 : int'(clk_per_bit);
    @(posedge clk);
    #1;
    if (r) begin
      byteq.delete();
      expq.delete();
      model_active = 1'b0;
      exp_tx = 1'b1;
    end else begin
      if (expq.size() == 0 && byteq.size() > 0) add_frame(byteq.pop_front(), p);
      if (acc) byteq.push_back(d);
      if (expq.size() > 0) begin
        exp_tx = expq.pop_front();
        model_active = 1'b1;
      end else begin
        exp_tx = 1'b1;
        model_active = 1'b0;
      end
    end
    last_acc = acc;
    check("uart_tx", uart_tx, exp_tx);
    check("busy", busy, model_active || byteq.size() > 0);
    check("s_tready", s_tready, !rst && byteq.size() < DEPTH);
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = b;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 2000);
    if (!last_acc) check("accept_timeout", 0, 1);
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((model_active || byteq.size() > 0 || expq.size() > 0) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check("drain_timeout", 0, 1);
    repeat (3) tick();
  endtask

  initial begin
    // reset held 3 cycles with valid asserted
    rst = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = 8'h5A;
    repeat (3) tick();
    rst = 1'b0;
    s_tvalid = 1'b0;
    tick();
    check("ready_after_rst", s_tready, 1);
    check("busy_after_rst", busy, 0);
    repeat (2) tick();

    // single byte at 4 clocks per bit
    clk_per_bit = 9'd4;
    send_byte(8'hA5);
    tick();
    check("a5_start", uart_tx, 0);
    drain();
    check("a5_idle", busy, 0);

    // back-to-back burst at 2 clocks per bit
    clk_per_bit = 9'd2;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    send_byte(8'h81);
    send_byte(8'h55);
    check("burst_full", s_tready, 0);
    drain();

    // divider edge cases: 0 and 1 both give one clock per bit
    clk_per_bit = 9'd0;
    send_byte(8'h0F);
    drain();
    clk_per_bit = 9'd1;
    send_byte(8'h0F);
    drain();

    // period change in the middle of a frame
    clk_per_bit = 9'd8;
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (19) tick();
    clk_per_bit = 9'd3;
    drain();

    // reset during data bit 3 with two bytes queued
    clk_per_bit = 9'd4;
    send_byte(8'hC3);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (15) tick();
    rst = 1'b1;
    tick();
    check("midrst_tx", uart_tx, 1);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    repeat (40) tick();
    check("midrst_quiet", busy, 0);

    // randomized traffic with occasional period changes
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(7, 0) == 0) clk_per_bit = CB'($urandom_range(5, 0));
      repeat ($urandom_range(3, 0)) tick();
      send_byte(DW'($urandom));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
